// File: rtl/branch_issue_ctrl.sv
// Branch issue control: round-robin pick between two scheduler slots feeding an
// in-order queue whose head is offered to the branch execute stage.
module branch_issue_ctrl #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iFREE_RESTART,
  input  logic                 iREQ0_VALID,
  input  logic [5:0]           iREQ0_COMMIT_TAG,
  input  logic [4:0]           iREQ0_CMD,
  input  logic [3:0]           iREQ0_CC,
  input  logic [4:0]           iREQ0_FLAG,
  input  logic [31:0]          iREQ0_SOURCE,
  input  logic [31:0]          iREQ0_PC,
  output logic                 oREQ0_LOCK,
  input  logic                 iREQ1_VALID,
  input  logic [5:0]           iREQ1_COMMIT_TAG,
  input  logic [4:0]           iREQ1_CMD,
  input  logic [3:0]           iREQ1_CC,
  input  logic [4:0]           iREQ1_FLAG,
  input  logic [31:0]          iREQ1_SOURCE,
  input  logic [31:0]          iREQ1_PC,
  output logic                 oREQ1_LOCK,
  output logic                 oEX_BRANCH_VALID,
  output logic [5:0]           oEX_BRANCH_COMMIT_TAG,
  output logic [4:0]           oEX_BRANCH_CMD,
  output logic [3:0]           oEX_BRANCH_CC,
  output logic [4:0]           oEX_BRANCH_FLAG,
  output logic [31:0]          oEX_BRANCH_SOURCE,
  output logic [31:0]          oEX_BRANCH_PC,
  input  logic                 iEX_BRANCH_LOCK,
  output logic [P_DEPTH_N:0]   oQUEUE_COUNT
);

  typedef struct packed {
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [3:0]  cc;
    logic [4:0]  flag;
    logic [31:0] source;
    logic [31:0] pc;
  } br_op_t;

  localparam logic [P_DEPTH_N:0] CNT_FULL = (P_DEPTH_N+1)'(P_DEPTH);

  br_op_t               req_op [2];
  br_op_t               win_op;
  br_op_t               entry_q [P_DEPTH];
  br_op_t               entry_d [P_DEPTH];
  br_op_t               head_op;

  logic [P_DEPTH_N:0]   count_q, count_d;
  logic [P_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic                 rr_last_q, rr_last_d;

  logic full, empty, push, pop, grant_idx;
  logic lock0, lock1;

  assign req_op[0] = '{iREQ0_COMMIT_TAG, iREQ0_CMD, iREQ0_CC, iREQ0_FLAG, iREQ0_SOURCE, iREQ0_PC};
  assign req_op[1] = '{iREQ1_COMMIT_TAG, iREQ1_CMD, iREQ1_CC, iREQ1_FLAG, iREQ1_SOURCE, iREQ1_PC};

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Grant never looks at the downstream lock, so a full queue blocks even on a pop cycle.
  always_comb begin
    push      = 1'b0;
    grant_idx = 1'b0;
    lock0     = 1'b0;
    lock1     = 1'b0;
    if (full || iFREE_RESTART) begin
      lock0 = 1'b1;
      lock1 = 1'b1;
    end else if (iREQ0_VALID && iREQ1_VALID) begin
      push      = 1'b1;
      grant_idx = ~rr_last_q;
      lock0     = grant_idx;
      lock1     = ~grant_idx;
    end else if (iREQ0_VALID) begin
      push      = 1'b1;
      grant_idx = 1'b0;
    end else if (iREQ1_VALID) begin
      push      = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign win_op = grant_idx ? req_op[1] : req_op[0];
  assign pop    = !empty && !iEX_BRANCH_LOCK && !iFREE_RESTART;

  always_comb begin
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rr_last_d = rr_last_q;
    if (iFREE_RESTART) begin
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      rr_last_d = 1'b1;
    end else begin
      if (push) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        rr_last_d = grant_idx;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < P_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (push && (wr_ptr_q == P_DEPTH_N'(i))) entry_d[i] = win_op;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rr_last_q <= 1'b1;
      for (int i = 0; i < P_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      rr_last_q <= rr_last_d;
      for (int i = 0; i < P_DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

  assign head_op = entry_q[rd_ptr_q];

  assign oREQ0_LOCK            = lock0;
  assign oREQ1_LOCK            = lock1;
  assign oEX_BRANCH_VALID      = pop;
  assign oEX_BRANCH_COMMIT_TAG = head_op.tag;
  assign oEX_BRANCH_CMD        = head_op.cmd;
  assign oEX_BRANCH_CC         = head_op.cc;
  assign oEX_BRANCH_FLAG       = head_op.flag;
  assign oEX_BRANCH_SOURCE     = head_op.source;
  assign oEX_BRANCH_PC         = head_op.pc;
  assign oQUEUE_COUNT          = count_q;

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Bench for branch_issue_ctrl: directed scenarios then random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_branch_issue_ctrl;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iFREE_RESTART = 1'b0;
  logic        r0_v = 1'b0, r1_v = 1'b0;
  logic [5:0]  r0_tag = '0, r1_tag = '0;
  logic [4:0]  r0_cmd = '0, r1_cmd = '0;
  logic [3:0]  r0_cc = '0, r1_cc = '0;
  logic [4:0]  r0_flag = '0, r1_flag = '0;
  logic [31:0] r0_src = '0, r1_src = '0;
  logic [31:0] r0_pc = '0, r1_pc = '0;
  logic        ex_lock = 1'b0;

  logic        oREQ0_LOCK, oREQ1_LOCK, oEX_BRANCH_VALID;
  logic [5:0]  oEX_BRANCH_COMMIT_TAG;
  logic [4:0]  oEX_BRANCH_CMD;
  logic [3:0]  oEX_BRANCH_CC;
  logic [4:0]  oEX_BRANCH_FLAG;
  logic [31:0] oEX_BRANCH_SOURCE, oEX_BRANCH_PC;
  logic [2:0]  oQUEUE_COUNT;

  branch_issue_ctrl #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iFREE_RESTART(iFREE_RESTART),
    .iREQ0_VALID(r0_v), .iREQ0_COMMIT_TAG(r0_tag), .iREQ0_CMD(r0_cmd), .iREQ0_CC(r0_cc),
    .iREQ0_FLAG(r0_flag), .iREQ0_SOURCE(r0_src), .iREQ0_PC(r0_pc), .oREQ0_LOCK(oREQ0_LOCK),
    .iREQ1_VALID(r1_v), .iREQ1_COMMIT_TAG(r1_tag), .iREQ1_CMD(r1_cmd), .iREQ1_CC(r1_cc),
    .iREQ1_FLAG(r1_flag), .iREQ1_SOURCE(r1_src), .iREQ1_PC(r1_pc), .oREQ1_LOCK(oREQ1_LOCK),
    .oEX_BRANCH_VALID(oEX_BRANCH_VALID), .oEX_BRANCH_COMMIT_TAG(oEX_BRANCH_COMMIT_TAG),
    .oEX_BRANCH_CMD(oEX_BRANCH_CMD), .oEX_BRANCH_CC(oEX_BRANCH_CC),
    .oEX_BRANCH_FLAG(oEX_BRANCH_FLAG), .oEX_BRANCH_SOURCE(oEX_BRANCH_SOURCE),
    .oEX_BRANCH_PC(oEX_BRANCH_PC), .iEX_BRANCH_LOCK(ex_lock), .oQUEUE_COUNT(oQUEUE_COUNT)
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct packed {
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [3:0]  cc;
    logic [4:0]  flag;
    logic [31:0] src;
    logic [31:0] pc;
  } ent_t;

  int         checks = 0;
  int         failures = 0;
  ent_t       mq[$];
  logic       m_rr = 1'b1;
  logic [5:0] issued[$];
  logic       s_lock0, s_lock1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [5:0] tag, input logic [31:0] pc);
    if (n == 0) begin
      r0_v = v; r0_tag = tag; r0_pc = pc; r0_src = $urandom;
      r0_cmd = 5'($urandom); r0_cc = 4'($urandom); r0_flag = 5'($urandom);
    end else begin
      r1_v = v; r1_tag = tag; r1_pc = pc; r1_src = $urandom;
      r1_cmd = 5'($urandom); r1_cc = 4'($urandom); r1_flag = 5'($urandom);
    end
  endtask

  // One clock: predict from the model, compare, then advance model and DUT together.
  task automatic cyc();
    int   g;
    logic el0, el1, ev;
    ent_t h;
    #2;
    g = -1; el0 = 1'b0; el1 = 1'b0;
    if (mq.size() == 4 || iFREE_RESTART) begin
      el0 = 1'b1; el1 = 1'b1;
    end else if (r0_v && r1_v) begin
      g = m_rr ? 0 : 1;
      el0 = (g == 1); el1 = (g == 0);
    end else if (r0_v) g = 0;
    else if (r1_v) g = 1;
    ev = (mq.size() != 0) && !ex_lock && !iFREE_RESTART;
    chk("lock0", 32'(oREQ0_LOCK), 32'(el0));
    chk("lock1", 32'(oREQ1_LOCK), 32'(el1));
    chk("ex_valid", 32'(oEX_BRANCH_VALID), 32'(ev));
    chk("count", 32'(oQUEUE_COUNT), 32'(mq.size()));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("head_tag", 32'(oEX_BRANCH_COMMIT_TAG), 32'(h.tag));
      chk("head_pc", oEX_BRANCH_PC, h.pc);
      chk("head_src", oEX_BRANCH_SOURCE, h.src);
      chk("head_ctl", {13'd0, oEX_BRANCH_CMD, oEX_BRANCH_CC, oEX_BRANCH_FLAG},
          {13'd0, h.cmd, h.cc, h.flag});
    end
    s_lock0 = oREQ0_LOCK;
    s_lock1 = oREQ1_LOCK;
    if (oEX_BRANCH_VALID) issued.push_back(oEX_BRANCH_COMMIT_TAG);
    @(posedge iCLOCK);
    if (iFREE_RESTART) begin
      mq.delete();
      m_rr = 1'b1;
    end else begin
      if (ev) void'(mq.pop_front());
      if (g == 0) mq.push_back('{r0_tag, r0_cmd, r0_cc, r0_flag, r0_src, r0_pc});
      if (g == 1) mq.push_back('{r1_tag, r1_cmd, r1_cc, r1_flag, r1_src, r1_pc});
      if (g >= 0) m_rr = (g == 1);
    end
    #1;
  endtask

  task automatic idle(input int n);
    r0_v = 1'b0; r1_v = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_valid", 32'(oEX_BRANCH_VALID), 32'd0);
    chk("rst_count", 32'(oQUEUE_COUNT), 32'd0);
    chk("rst_tag", 32'(oEX_BRANCH_COMMIT_TAG), 32'd0);
    chk("rst_pc", oEX_BRANCH_PC, 32'd0);
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;

    // 1: single op, one-cycle latency
    set_req(0, 1'b1, 6'h05, 32'h100);
    cyc();
    chk("t1_count", 32'(oQUEUE_COUNT), 32'd1);
    r0_v = 1'b0;
    cyc();
    chk("t1_issue", 32'(issued.size()), 32'd1);
    if (issued.size() > 0) chk("t1_tag", 32'(issued[0]), 32'h05);
    chk("t1_count0", 32'(oQUEUE_COUNT), 32'd0);

    // 2: alternating grants from a fresh round-robin state
    iFREE_RESTART = 1'b1; cyc(); iFREE_RESTART = 1'b0;
    issued.delete();
    set_req(0, 1'b1, 6'h01, 32'h200);
    set_req(1, 1'b1, 6'h11, 32'h300);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (!s_lock0) set_req(0, 1'b1, r0_tag + 6'd1, r0_pc + 32'd4);
      if (!s_lock1) set_req(1, 1'b1, r1_tag + 6'd1, r1_pc + 32'd4);
    end
    idle(5);
    chk("t2_n", 32'(issued.size()), 32'd4);
    if (issued.size() == 4) begin
      chk("t2_o0", 32'(issued[0]), 32'h01);
      chk("t2_o1", 32'(issued[1]), 32'h11);
      chk("t2_o2", 32'(issued[2]), 32'h02);
      chk("t2_o3", 32'(issued[3]), 32'h12);
    end

    // 3: fill to capacity under downstream lock, then drain
    issued.delete();
    ex_lock = 1'b1;
    set_req(0, 1'b1, 6'h21, 32'h400);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (!s_lock0) set_req(0, 1'b1, r0_tag + 6'd1, r0_pc + 32'd4);
    end
    chk("t3_full", 32'(oQUEUE_COUNT), 32'd4);
    chk("t3_lock", 32'(s_lock0), 32'd1);
    ex_lock = 1'b0;
    idle(5);
    chk("t3_n", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      chk("t3_order", 32'(issued[i]), 32'h21 + 32'(i));

    // 4: full with pop blocks the push; accepted next cycle; write pointer wraps
    issued.delete();
    ex_lock = 1'b1;
    set_req(1, 1'b1, 6'h31, 32'h500);
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_req(1, 1'b1, r1_tag + 6'd1, r1_pc + 32'd4);
    end
    ex_lock = 1'b0;
    cyc();
    chk("t4_blocked", 32'(s_lock1), 32'd1);
    cyc();
    chk("t4_accept", 32'(s_lock1), 32'd0);
    idle(6);
    chk("t4_n", 32'(issued.size()), 32'd5);
    for (int i = 0; i < 5 && i < issued.size(); i++)
      chk("t4_order", 32'(issued[i]), 32'h31 + 32'(i));

    // 5: flush with three queued and a pending request
    issued.delete();
    ex_lock = 1'b1;
    set_req(0, 1'b1, 6'h01, 32'h600);
    for (int i = 0; i < 3; i++) begin
      cyc();
      set_req(0, 1'b1, r0_tag + 6'd1, r0_pc + 32'd4);
    end
    iFREE_RESTART = 1'b1;
    cyc();
    iFREE_RESTART = 1'b0;
    chk("t5_count", 32'(oQUEUE_COUNT), 32'd0);
    ex_lock = 1'b0;
    set_req(0, 1'b1, 6'h3A, 32'h700);
    cyc();
    idle(2);
    chk("t5_n", 32'(issued.size()), 32'd1);
    if (issued.size() > 0) chk("t5_tag", 32'(issued[0]), 32'h3A);

    // 6: async reset mid-stream; priority restarts at REQ0
    ex_lock = 1'b1;
    set_req(0, 1'b1, 6'h0A, 32'h800);
    cyc();
    set_req(0, 1'b1, 6'h0B, 32'h804);
    cyc();
    r0_v = 1'b0;
    chk("t6_pre", 32'(oQUEUE_COUNT), 32'd2);
    #2 inRESET = 1'b0;
    #1;
    chk("t6_valid", 32'(oEX_BRANCH_VALID), 32'd0);
    chk("t6_count", 32'(oQUEUE_COUNT), 32'd0);
    chk("t6_tag", 32'(oEX_BRANCH_COMMIT_TAG), 32'd0);
    chk("t6_src", oEX_BRANCH_SOURCE, 32'd0);
    mq.delete();
    m_rr = 1'b1;
    @(posedge iCLOCK); #1;
    inRESET = 1'b1;
    ex_lock = 1'b0;
    set_req(0, 1'b1, 6'h0C, 32'h900);
    set_req(1, 1'b1, 6'h1C, 32'hA00);
    cyc();
    chk("t6_rr0", 32'(s_lock0), 32'd0);
    chk("t6_rr1", 32'(s_lock1), 32'd1);
    idle(3);

    // Random traffic; slots hold an op while locked
    for (int i = 0; i < 600; i++) begin
      ex_lock = ($urandom_range(0, 9) < 3);
      iFREE_RESTART = ($urandom_range(0, 39) == 0);
      cyc();
      if (!r0_v || !s_lock0) set_req(0, 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
      if (!r1_v || !s_lock1) set_req(1, 1'($urandom_range(0, 1)), 6'($urandom), $urandom);
    end
    iFREE_RESTART = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
